// File: rtl/bus_arbiter.sv
// Two-master (icache/dcache) arbiter onto a single downstream bus port with timeout abort.
// Define BUS_ARB_RR_EN for round-robin tie break; otherwise the dcache wins ties.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // icache
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_error,
  // dcache
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_error,
  // downstream
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_error,
  output logic        busy
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e          state_q, state_d;
  logic            last_d_q, last_d_d;  // 1: dcache was the most recent grant
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [31:0]     m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic [3:0]      m_wstrb_q, m_wstrb_d;

  logic            pick_i, pick_d;
  logic            timeout_hit;
  logic            done;
  logic [31:0]     resp_rdata;
  logic            resp_error;

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_req && d_req) begin
`ifdef BUS_ARB_RR_EN
      pick_i = last_d_q;
      pick_d = !last_d_q;
`else
      pick_d = 1'b1;
`endif
    end else begin
      pick_i = i_req;
      pick_d = d_req;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast) && !m_ready;
  assign done        = (state_q != StIdle) && (m_ready || timeout_hit);

  // A real response wins over a coincident timeout.
  assign resp_rdata = m_ready ? m_rdata : 32'h0;
  assign resp_error = m_ready ? m_error : 1'b1;

  always_comb begin
    i_ready = (state_q == StGntI) && done && i_req;
    d_ready = (state_q == StGntD) && done && d_req;
    i_rdata = i_ready ? resp_rdata : 32'h0;
    i_error = i_ready ? resp_error : 1'b0;
    d_rdata = d_ready ? resp_rdata : 32'h0;
    d_error = d_ready ? resp_error : 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    case (state_q)
      StIdle: begin
        if (pick_i) begin
          state_d   = StGntI;
          last_d_d  = 1'b0;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = 32'h0;
          m_wstrb_d = 4'h0;
        end else if (pick_d) begin
          state_d   = StGntD;
          last_d_d  = 1'b1;
          cnt_d     = '0;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_wstrb_d = d_wstrb;
        end
      end
      StGntI, StGntD: begin
        if (m_ready || timeout_hit) begin
          state_d = StIdle;
          m_req_d = 1'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b1;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single SystemBus downstream port between the instruction cache (fetch refills) and the data cache (memory-stage loads/stores). It sits between both caches and the memory bus. It latches one request per grant, holds the downstream request stable until completion or timeout, and routes the response back only to the master that still wants it. A master that withdraws on a pipeline flush never corrupts or blocks the other master.

## Interface
- TIMEOUT, 255, downstream cycles without `m_ready` before abort; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  icache read request, level.
- i_addr  in  32  icache read address.
- i_ready  out  1  icache response valid, 1-cycle pulse.
- i_rdata  out  32  icache read data, valid with `i_ready`.
- i_error  out  1  icache bus error/timeout, valid with `i_ready`.
- d_req  in  1  dcache request, level.
- d_we  in  1  dcache write enable.
- d_addr  in  32  dcache address.
- d_wdata  in  32  dcache write data.
- d_wstrb  in  4  dcache byte strobes.
- d_ready  out  1  dcache response pulse.
- d_rdata  out  32  dcache read data.
- d_error  out  1  dcache error, valid with `d_ready`.
- m_req, m_we, m_addr, m_wdata, m_wstrb  out  1/1/32/32/4  downstream request, registered.
- m_ready, m_rdata, m_error  in  1/32/1  downstream response.
- busy  out  1  high in any grant state.

## Operation
- States:
  - IDLE
  - GNT_I
  - GNT_D
- IDLE behaviour:
  - Samples `i_req`/`d_req` and picks a winner (see Configuration).
  - Latches the winner's request fields into `m_*` registers and moves to GNT_x.
  - The icache request is latched with `m_we=0` and `m_wstrb=0`.
- GNT_x behaviour:
  - `m_req=1` and all `m_*` fields stay constant.
  - Master input changes are ignored until the transaction ends.
- Completion: on `m_ready=1`:
  - Forward `m_rdata` and `m_error` to master x, with x_ready=1 only if x_req is still high that cycle.
  - If x_req is low, the response is discarded (withdrawn master).
  - Deassert `m_req` next cycle and return to IDLE.
- Timeout:
  - `cnt` clears on grant and increments each GNT cycle without `m_ready`.
  - When `cnt==TIMEOUT-1` with no `m_ready`: pulse x_ready=1, x_error=1, x_rdata=0 (masked if x_req is low) and go to IDLE.
  - `m_ready` in the same cycle wins: normal completion.
- The non-granted master's ready, rdata and error are held at 0.
- `last_grant` records the most recently granted master and updates on every IDLE→GNT transition.

## Timing
- All outputs are 0 during and after reset.
- `last_grant` resets to D, so the first tie goes to I.
- Reset assertion mid-transaction drops `m_req` immediately (async) and returns to IDLE. No response is issued.
- Request to downstream:
  - x_req rises in cycle 0 with the arbiter in IDLE.
  - `m_req=1` from cycle 1.
- Response path: x_ready is combinational from `m_ready` in the same cycle (zero added latency).
- Back-to-back:
  - Completion in cycle n puts the arbiter in IDLE at n+1.
  - Next `m_req` at n+2: one bubble per transaction.
- A master must hold x_req and its fields stable until x_ready. After x_ready it must drop x_req or present a new request; a still-high x_req in IDLE is treated as a new request.
- Counter width is `$clog2(TIMEOUT+1)`. The counter saturates, never wraps.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin tie break. When both request in IDLE, grant the master that is not `last_grant`.
- `BUS_ARB_RR_EN` undefined: fixed priority, dcache always wins ties. Icache is served only when `d_req=0` in IDLE. `last_grant` is still maintained but unused.

## Test plan
- Single icache read:
  - Stimulus: i_req with i_addr=0x80000000; m_ready at the 3rd grant cycle with m_rdata=0x00000013.
  - Response: m_req high cycles 1–3 with m_addr=0x80000000, m_we=0; i_ready=1 and i_rdata=0x13 in cycle 3; d_ready=0 throughout.
- Simultaneous requests:
  - Stimulus: i_req and d_req (write 0xDEADBEEF to 0x80001000, wstrb=0xF) asserted together out of reset, each served with 1-cycle latency.
  - Response with RR: icache first, then dcache with m_wdata=0xDEADBEEF.
  - Response without RR: dcache first.
- Withdrawal:
  - Stimulus: icache granted, i_req dropped (flush) before m_ready.
  - Response: m_req stays high until m_ready; i_ready stays 0; a pending d_req is granted 2 cycles after completion.
- Timeout:
  - Stimulus: TIMEOUT=4, d_req asserted, m_ready never asserted.
  - Response: in grant cycle 4, d_ready=1, d_error=1, d_rdata=0; m_req=0 next cycle.
- Timeout/ready collision:
  - Stimulus: TIMEOUT=4, m_ready asserted in grant cycle 4 with m_rdata=0x55.
  - Response: d_error=0, d_rdata=0x55.
- Async reset:
  - Stimulus: rst pulled low mid-grant, between clock edges.
  - Response: m_req, busy and all ready outputs go to 0 before the next edge; the arbiter restarts in IDLE.
